// File: rtl/conveyor_loader.sv
// Load engine feeding conveyor slots: clears the slot on accept, queues the request, and writes the result back with a fault code.
// Latency: accept at T, pop at T+1, read issued at T+2, completion write one cycle after the memory response.
// Backpressure: req_ready drops when the queue is full or when the request would clear the slot completing next cycle; mem_rd_valid holds until mem_rd_ready.
module conveyor_loader #(
  parameter int WORD_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 32,
  parameter int CONVEYOR_ADDR_WIDTH = 4,
  parameter int QUEUE_ADDR_WIDTH    = 2,
  parameter logic [2:0] BUS_FAULT   = 3'd1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [CONVEYOR_ADDR_WIDTH-1:0] req_slot,
  input  logic                           req_conveyor,
  output logic                           clr_en,
  output logic                           clr_conveyor,
  output logic [CONVEYOR_ADDR_WIDTH-1:0] clr_slot,
  output logic                           mem_rd_valid,
  input  logic                           mem_rd_ready,
  output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
  input  logic                           mem_resp_valid,
  input  logic [WORD_WIDTH-1:0]          mem_resp_data,
  input  logic                           mem_resp_error,
  output logic                           wr_en,
  output logic                           wr_conveyor,
  output logic [CONVEYOR_ADDR_WIDTH-1:0] wr_slot,
  output logic [WORD_WIDTH-1:0]          wr_value,
  output logic [2:0]                     wr_fault,
  output logic                           busy
);

  localparam int DEPTH = 1 << QUEUE_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]          q_addr [DEPTH];
  logic [CONVEYOR_ADDR_WIDTH-1:0] q_slot [DEPTH];
  logic                           q_conv [DEPTH];
  logic [QUEUE_ADDR_WIDTH:0]      wr_ptr, rd_ptr;
  logic                           empty, full, push, pop;

  logic [ADDR_WIDTH-1:0]          active_addr;
  logic [CONVEYOR_ADDR_WIDTH-1:0] active_slot;
  logic                           active_conv;
  logic                           wr_en_next, hazard;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (identical).
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[QUEUE_ADDR_WIDTH] != rd_ptr[QUEUE_ADDR_WIDTH]) &&
                 (wr_ptr[QUEUE_ADDR_WIDTH-1:0] == rd_ptr[QUEUE_ADDR_WIDTH-1:0]);
  assign pop   = (state == IDLE) && !empty;

  // A clear must not land on the slot whose completion is being registered this cycle.
  assign wr_en_next = (state == WAIT) && mem_resp_valid;
  assign hazard     = wr_en_next && (req_conveyor == active_conv) && (req_slot == active_slot);

  // A pop in the same cycle frees an entry, so a full queue can still accept.
  assign req_ready = (!full || pop) && !hazard;
  assign push      = req_valid && req_ready;

  assign clr_en       = push;
  assign clr_slot     = req_slot;
  assign clr_conveyor = req_conveyor;

  assign mem_rd_valid = (state == ISSUE);
  assign mem_rd_addr  = active_addr;
  assign busy         = !empty || (state != IDLE) || wr_en;

  // Queue pointers: advance on push/pop, wrap modulo twice the depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Queue storage: write the accepted request at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr[QUEUE_ADDR_WIDTH-1:0]] <= req_addr;
      q_slot[wr_ptr[QUEUE_ADDR_WIDTH-1:0]] <= req_slot;
      q_conv[wr_ptr[QUEUE_ADDR_WIDTH-1:0]] <= req_conveyor;
    end
  end

  // Active request registers: loaded from the queue head on pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_addr <= '0;
      active_slot <= '0;
      active_conv <= 1'b0;
    end else if (pop) begin
      active_addr <= q_addr[rd_ptr[QUEUE_ADDR_WIDTH-1:0]];
      active_slot <= q_slot[rd_ptr[QUEUE_ADDR_WIDTH-1:0]];
      active_conv <= q_conv[rd_ptr[QUEUE_ADDR_WIDTH-1:0]];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: one read in flight at a time, strictly in queue order.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty)        state_next = ISSUE;
      ISSUE:   if (mem_rd_ready)  state_next = WAIT;
      WAIT:    if (mem_resp_valid) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Completion write: one-cycle strobe, error responses write zero data with the bus fault code.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_slot     <= '0;
      wr_conveyor <= 1'b0;
      wr_value    <= '0;
      wr_fault    <= 3'd0;
    end else begin
      wr_en <= wr_en_next;
      if (wr_en_next) begin
        wr_slot     <= active_slot;
        wr_conveyor <= active_conv;
        wr_value    <= mem_resp_error ? '0 : mem_resp_data;
        wr_fault    <= mem_resp_error ? BUS_FAULT : 3'd0;
      end
    end
  end

endmodule

// File: tb/tb_conveyor_loader.sv
// Directed bench for conveyor_loader: memory responder model plus scoreboard of expected slot writes.
module tb_conveyor_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [3:0]  req_slot;
  logic        req_conveyor;
  logic        clr_en;
  logic        clr_conveyor;
  logic [3:0]  clr_slot;
  logic        mem_rd_valid;
  logic        mem_rd_ready;
  logic [31:0] mem_rd_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_error;
  logic        wr_en;
  logic        wr_conveyor;
  logic [3:0]  wr_slot;
  logic [31:0] wr_value;
  logic [2:0]  wr_fault;
  logic        busy;

  always #5 clk = ~clk;

  conveyor_loader dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_slot(req_slot), .req_conveyor(req_conveyor),
    .clr_en(clr_en), .clr_conveyor(clr_conveyor), .clr_slot(clr_slot),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_error(mem_resp_error),
    .wr_en(wr_en), .wr_conveyor(wr_conveyor), .wr_slot(wr_slot),
    .wr_value(wr_value), .wr_fault(wr_fault), .busy(busy)
  );

  typedef struct packed {
    logic [3:0]  slot;
    logic        conv;
    logic [31:0] value;
    logic [2:0]  fault;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Memory contents model; addresses with bit 31 set return a bus error.
  function automatic logic [31:0] model_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_1234);
  endfunction

  function automatic logic model_err(input logic [31:0] a);
    return a[31];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: replies one cycle after each read handshake unless suppressed.
  logic        hs_seen = 1'b0;
  logic [31:0] hs_addr = '0;
  logic        resp_suppress = 1'b0;
  logic        auto_valid = 1'b0, auto_err = 1'b0;
  logic [31:0] auto_data = '0;
  logic        man_valid = 1'b0, man_err = 1'b0;
  logic [31:0] man_data = '0;

  assign mem_resp_valid = auto_valid | man_valid;
  assign mem_resp_data  = auto_valid ? auto_data : man_data;
  assign mem_resp_error = auto_valid ? auto_err  : man_err;

  always @(posedge clk) begin
    hs_seen = mem_rd_valid && mem_rd_ready && !reset;
    if (hs_seen) hs_addr = mem_rd_addr;
  end

  always @(negedge clk) begin
    auto_valid = hs_seen && !resp_suppress;
    auto_data  = auto_valid ? model_data(hs_addr) : 32'h0;
    auto_err   = auto_valid && model_err(hs_addr);
  end

  // Completion monitor: every slot write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL wr_unexpected observed slot=%0d value=0x%0h expected no write", wr_slot, wr_value);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wr_slot",  64'(wr_slot),     64'(e.slot));
        check("wr_conv",  64'(wr_conveyor), 64'(e.conv));
        check("wr_value", 64'(wr_value),    64'(e.value));
        check("wr_fault", 64'(wr_fault),    64'(e.fault));
      end
    end
  end

  // Present a request (starting just after a negedge), wait for acceptance, record expectation.
  task automatic send(input logic [31:0] a, input logic [3:0] s, input logic c);
    exp_t e;
    int   n = 0;
    req_valid = 1'b1; req_addr = a; req_slot = s; req_conveyor = c;
    #1;
    while (!req_ready && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("accept", 64'(req_ready), 64'd1);
    check("clr_en", 64'(clr_en), 64'd1);
    check("clr_slot", 64'({clr_conveyor, clr_slot}), 64'({c, s}));
    e.slot = s; e.conv = c;
    e.value = model_err(a) ? 32'h0 : model_data(a);
    e.fault = model_err(a) ? 3'd1 : 3'd0;
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk); n++;
    end
    check(tag, 64'(sb.size() == 0 && !busy), 64'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_slot = '0; req_conveyor = 1'b0;
    mem_rd_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_clr_en", 64'(clr_en), 64'd0);
    check("rst_rd_valid", 64'(mem_rd_valid), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
    check("rst_wr_fields", 64'({wr_value, wr_slot, wr_conveyor, wr_fault}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single load, exact latency
    send(32'h100, 4'd3, 1'b0);
    check("t1_rd_valid", 64'(mem_rd_valid), 64'd0);
    @(negedge clk);
    check("t2_rd_valid", 64'(mem_rd_valid), 64'd1);
    check("t2_rd_addr", 64'(mem_rd_addr), 64'h100);
    @(negedge clk);
    check("t3_rd_valid", 64'(mem_rd_valid), 64'd0);
    check("t3_wr_en", 64'(wr_en), 64'd0);
    @(negedge clk);
    check("t4_wr_en", 64'(wr_en), 64'd1);
    drain("drain_single");

    // Bus error
    send(32'h8000_0040, 4'd7, 1'b0);
    drain("drain_error");

    // Fill the queue with memory stalled
    mem_rd_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(32'h1000 + 32'(i) * 4, 4'(i), 1'b0);
    check("fill_busy", 64'(busy), 64'd1);
    req_valid = 1'b1; req_addr = 32'h2000; req_slot = 4'd6; req_conveyor = 1'b0;
    #1;
    check("full_ready", 64'(req_ready), 64'd0);
    check("full_clr_en", 64'(clr_en), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    mem_rd_ready = 1'b1;
    for (int i = 0; i < 50 && !wr_en; i++) @(negedge clk);
    check("first_wr_seen", 64'(wr_en), 64'd1);
    check("full_pop_ready", 64'(req_ready), 64'd1);
    drain("drain_fill");

    // Same-slot hazard
    resp_suppress = 1'b1;
    send(32'h200, 4'd5, 1'b0);
    for (int i = 0; i < 20 && !mem_rd_valid; i++) @(negedge clk);
    check("hz_issue", 64'(mem_rd_valid), 64'd1);
    @(negedge clk);
    man_valid = 1'b1; man_data = model_data(32'h200); man_err = 1'b0;
    req_valid = 1'b1; req_addr = 32'h300; req_slot = 4'd5; req_conveyor = 1'b0;
    #1;
    check("hz_ready", 64'(req_ready), 64'd0);
    check("hz_clr_en", 64'(clr_en), 64'd0);
    @(negedge clk);
    man_valid = 1'b0;
    resp_suppress = 1'b0;
    send(32'h300, 4'd5, 1'b0);
    drain("drain_hazard");

    // Reset in WAIT with two queued, then a late response
    resp_suppress = 1'b1;
    send(32'h400, 4'd8, 1'b0);
    send(32'h404, 4'd9, 1'b0);
    send(32'h408, 4'd10, 1'b0);
    for (int i = 0; i < 20 && !mem_rd_valid; i++) @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    resp_suppress = 1'b0;
    man_valid = 1'b1; man_data = 32'h1234_5678; man_err = 1'b0;
    @(negedge clk);
    man_valid = 1'b0;
    check("late_wr_en_a", 64'(wr_en), 64'd0);
    repeat (3) @(negedge clk);
    check("late_wr_en_b", 64'(wr_en), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    check("post_rst_rd_valid", 64'(mem_rd_valid), 64'd0);

    // Interrupt conveyor, top slot
    send(32'h44, 4'hF, 1'b1);
    drain("drain_irq");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
